or_fold_arbiter: RTL and testbench

- Shares one byte-fold unit (result = data[DATA_W-1:HALF] | data[HALF-1:0]) among NUM_REQ requesters, each presenting a DATA_W-bit word.
- A round-robin arbiter picks one requester per accepted transaction.
- The fold result is registered and returned on a single valid/ready response channel, tagged with the requester index.
- Sits between the byte-pair producers and any downstream consumer of OR-combined bytes; it replaces per-requester fold instances.

---
 rtl/or_fold_arbiter.sv | 130 +++++++++++++
 tb/tb_or_fold_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/or_fold_arbiter.sv
// Round-robin shared OR-fold unit: one requester per accepted transaction,
// the hi|lo fold of its word returned through a single registered response slot.
module or_fold_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W/2-1:0]       rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          done_count
);

    localparam int HALF  = DATA_W / 2;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e             slot_q, slot_d;
    logic [HALF-1:0]   data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   win_s;
    logic              can_accept_s;
    logic              accept_s;
    logic [DATA_W-1:0] word_s [NUM_REQ];

    function automatic logic [HALF-1:0] fold_word(input logic [DATA_W-1:0] w);
        return w[DATA_W-1:HALF] | w[HALF-1:0];
    endfunction

    // First valid requester strictly after ptr, wrapping around.
    function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                    input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] win;
        logic            found;
        int              cand;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[cand[IDX_W-1:0]]) begin
                win   = cand[ID_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign word_s[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Winner selection and one-hot accept, suppressed while in reset.
    always_comb begin
        win_s        = pick_winner(req_valid, ptr_q);
        can_accept_s = (slot_q == SLOT_EMPTY) || rsp_ready;
        accept_s     = 1'b0;
        req_ready    = '0;
        if (rst_n && can_accept_s && (|req_valid)) begin
            accept_s  = 1'b1;
            req_ready = NUM_REQ'(1) << win_s;
        end else begin
            accept_s  = 1'b0;
            req_ready = '0;
        end
    end

    // Next state of the response slot, pointer and completion counter.
    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (accept_s) begin
            slot_d = SLOT_FULL;
            data_d = fold_word(word_s[win_s]);
            id_d   = win_s;
            ptr_d  = win_s;
        end else if (rsp_ready) begin
            slot_d = SLOT_EMPTY;
        end else begin
            slot_d = slot_q;
        end
        // Counter saturates instead of wrapping.
        if ((slot_q == SLOT_FULL) && rsp_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; pointer starts at the last index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_EMPTY;
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= ID_W'(NUM_REQ - 1);
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rsp_valid  = (slot_q == SLOT_FULL);
    assign busy       = (slot_q == SLOT_FULL);
    assign rsp_data   = data_q;
    assign rsp_id     = id_q;
    assign done_count = cnt_q;

endmodule

// File: tb/tb_or_fold_arbiter.sv
// Directed and random checks of or_fold_arbiter against a cycle-level reference model.
module tb_or_fold_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [63:0] req_data = 64'h0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [3:0]  done_count;

    int total = 0;
    int bad   = 0;

    int         m_ptr;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_id;
    int         m_cnt;

    or_fold_arbiter #(
        .NUM_REQ(4), .DATA_W(16), .ID_W(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 3; m_valid = 1'b0; m_data = 8'h00; m_id = 0; m_cnt = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic [3:0] v, input logic [63:0] d, input logic r);
        int         w;
        logic [3:0] exp_rdy;
        logic [15:0] word;
        @(negedge clk);
        req_valid = v; req_data = d; rsp_ready = r;
        #1;
        w = m_winner(v);
        exp_rdy = 4'b0000;
        if ((!m_valid || r) && w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("busy", busy, m_valid);
        chk("done_count", done_count, m_cnt);
        if (m_valid) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", rsp_id, m_id);
        end
        if (m_valid && r) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        if (exp_rdy != 4'b0000) begin
            word    = d[w*16 +: 16];
            m_data  = word[15:8] | word[7:0];
            m_id    = w;
            m_ptr   = w;
            m_valid = 1'b1;
        end else if (r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'hF; req_data = 64'h0; rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_count", done_count, 4'h0);
        model_reset();
        @(negedge clk);
        req_valid = 4'h0;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single request from requester 2
        step(4'b0100, 64'h0000_A50F_0000_0000, 1'b1);
        chk("t1_grant", req_ready, 4'b0100);
        step(4'b0000, 64'h0, 1'b1);
        chk("t1_data", rsp_data, 8'hAF);
        chk("t1_id", rsp_id, 2'd2);
        step(4'b0000, 64'h0, 1'b1);
        chk("t1_count", done_count, 4'd1);

        // Round-robin with all requesters active
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, {$urandom, $urandom}, 1'b1);
            chk("t2_rr_grant", req_ready, 4'b0001 << (i % 4));
        end
        step(4'b0000, 64'h0, 1'b1);
        step(4'b0000, 64'h0, 1'b1);
        chk("t2_count", done_count, 4'd8);

        // Backpressure holds the response and blocks grants
        do_reset();
        step(4'b0010, 64'h0000_0000_1234_0000, 1'b0);
        chk("t3_grant", req_ready, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            step(4'b1011, {$urandom, $urandom}, 1'b0);
            chk("t3_hold_data", rsp_data, 8'h36);
            chk("t3_hold_id", rsp_id, 2'd1);
            chk("t3_hold_ready", req_ready, 4'b0000);
        end
        step(4'b1011, {$urandom, $urandom}, 1'b1);
        chk("t3_release_grant", req_ready, 4'b1000);
        step(4'b0000, 64'h0, 1'b1);
        chk("t3_count", done_count, 4'd1);

        // Pointer holds across backpressure
        do_reset();
        step(4'b0100, {$urandom, $urandom}, 1'b1);
        step(4'b1001, {$urandom, $urandom}, 1'b0);
        step(4'b1001, {$urandom, $urandom}, 1'b0);
        chk("t4_blocked", req_ready, 4'b0000);
        step(4'b1001, {$urandom, $urandom}, 1'b1);
        chk("t4_first", req_ready, 4'b1000);
        step(4'b1001, {$urandom, $urandom}, 1'b1);
        chk("t4_second", req_ready, 4'b0001);

        // X on non-winning words must not reach the response
        step(4'b0010, 64'hxxxx_xxxx_5A3C_xxxx, 1'b1);
        step(4'b0000, 64'hxxxx_xxxx_xxxx_xxxx, 1'b0);
        chk("t_x_data", rsp_data, 8'h7E);

        // Asynchronous reset while a response is held
        do_reset();
        step(4'b0001, {$urandom, $urandom}, 1'b1);
        step(4'b0100, {$urandom, $urandom}, 1'b1);
        step(4'b1111, {$urandom, $urandom}, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_count", done_count, 4'd0);
        chk("t5_id", rsp_id, 2'd0);
        chk("t5_ready", req_ready, 4'b0000);
        model_reset();
        @(negedge clk);
        req_valid = 4'h0;
        rst_n = 1'b1;
        step(4'b1111, {$urandom, $urandom}, 1'b1);
        chk("t5_first_after_reset", req_ready, 4'b0001);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) step(4'b1111, {$urandom, $urandom}, 1'b1);
        step(4'b0000, 64'h0, 1'b1);
        chk("t6_saturate", done_count, 4'hF);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(4'($urandom_range(0, 15)), {$urandom, $urandom}, ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
